// File: rtl/cell_sequencer.sv
// Sweeps a 9x9 cell grid with a query per cell, repeating passes until all cells report solved.
// Define CELL_SEQUENCER_TIMEOUT_EN to bound each WAIT at TIMEOUT cycles and flag timeout_err.
module cell_sequencer #(
   parameter int unsigned TIMEOUT   = 15,
   parameter int unsigned MAX_PASS  = 9,
   parameter logic [3:0]  CMD_QUERY = 4'h1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic [3:0] cell_row,
   output logic [3:0] cell_col,
   output logic [3:0] cell_cmd,
   output logic [3:0] cell_data,
   output logic       cell_data_rdy,
   input  logic       cell_data_valid,
   input  logic       cell_solved,
   output logic [6:0] solved_cnt,
   output logic [3:0] pass,
   output logic       grid_solved,
   output logic       timeout_err
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      NEXT  = 3'd3,
      EVAL  = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam logic [3:0] LAST_IDX  = 4'd8;
   localparam logic [3:0] LAST_PASS = 4'(MAX_PASS - 1);
   localparam logic [6:0] ALL_CELLS = 7'd81;

   if (TIMEOUT == 0 || TIMEOUT > 255 || MAX_PASS == 0 || MAX_PASS > 15) begin : g_param_check
      $error("cell_sequencer: TIMEOUT or MAX_PASS out of range");
   end

   state_t     state_q;
   logic       busy_q, done_q, rdy_q, grid_q;
   logic [3:0] row_q, col_q, pass_q, cmd_q, data_q;
   logic [6:0] run_cnt_q, solved_q;
   logic [3:0] row_d, col_d;
   logic       last_cell;

   // Raster order: column fastest, row wraps after column 8.
   always_comb begin
      row_d     = row_q;
      col_d     = col_q + 4'd1;
      last_cell = (row_q == LAST_IDX) && (col_q == LAST_IDX);
      if (col_q == LAST_IDX) begin
         col_d = '0;
         row_d = row_q + 4'd1;
      end
   end

`ifdef CELL_SEQUENCER_TIMEOUT_EN
   logic [7:0] tmo_q;
   logic       tmo_err_q;
   assign timeout_err = tmo_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rdy_q     <= 1'b0;
         cmd_q     <= '0;
         data_q    <= '0;
         grid_q    <= 1'b0;
         row_q     <= '0;
         col_q     <= '0;
         pass_q    <= '0;
         run_cnt_q <= '0;
         solved_q  <= '0;
`ifdef CELL_SEQUENCER_TIMEOUT_EN
         tmo_q     <= '0;
         tmo_err_q <= 1'b0;
`endif
      end else begin
         // Strobe-related outputs default low; only a transition into ISSUE raises them.
         done_q <= 1'b0;
         rdy_q  <= 1'b0;
         cmd_q  <= '0;
         data_q <= '0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q   <= ISSUE;
                  busy_q    <= 1'b1;
                  row_q     <= '0;
                  col_q     <= '0;
                  pass_q    <= '0;
                  run_cnt_q <= '0;
                  solved_q  <= '0;
                  grid_q    <= 1'b0;
                  rdy_q     <= 1'b1;
                  cmd_q     <= CMD_QUERY;
                  data_q    <= '0;
`ifdef CELL_SEQUENCER_TIMEOUT_EN
                  tmo_err_q <= 1'b0;
`endif
               end
            end
            ISSUE: begin
               state_q <= WAIT;
`ifdef CELL_SEQUENCER_TIMEOUT_EN
               tmo_q   <= '0;
`endif
            end
            WAIT: begin
               if (cell_data_valid) begin
                  if (cell_solved) run_cnt_q <= run_cnt_q + 7'd1;
                  state_q <= NEXT;
               end
`ifdef CELL_SEQUENCER_TIMEOUT_EN
               else if (tmo_q == 8'(TIMEOUT - 1)) begin
                  tmo_err_q <= 1'b1;
                  state_q   <= NEXT;
               end else begin
                  tmo_q <= tmo_q + 8'd1;
               end
`endif
            end
            NEXT: begin
               if (last_cell) begin
                  state_q <= EVAL;
               end else begin
                  row_q   <= row_d;
                  col_q   <= col_d;
                  state_q <= ISSUE;
                  rdy_q   <= 1'b1;
                  cmd_q   <= CMD_QUERY;
                  data_q  <= pass_q;
               end
            end
            EVAL: begin
               solved_q <= run_cnt_q;
               if (run_cnt_q == ALL_CELLS) begin
                  grid_q  <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else if (pass_q == LAST_PASS) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  pass_q    <= pass_q + 4'd1;
                  row_q     <= '0;
                  col_q     <= '0;
                  run_cnt_q <= '0;
                  state_q   <= ISSUE;
                  rdy_q     <= 1'b1;
                  cmd_q     <= CMD_QUERY;
                  data_q    <= pass_q + 4'd1;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign cell_row      = row_q;
   assign cell_col      = col_q;
   assign cell_cmd      = cmd_q;
   assign cell_data     = data_q;
   assign cell_data_rdy = rdy_q;
   assign solved_cnt    = solved_q;
   assign pass          = pass_q;
   assign grid_solved   = grid_q;

endmodule

// File: tb/tb_cell_sequencer.sv
// Scoreboard bench for cell_sequencer: expected strobes and done reports are queued by the
// stimulus and popped by a negedge monitor; a responder process models the addressed cell.
module tb_cell_sequencer;

   logic       clk = 1'b0;
   logic       rst_n, start;
   logic       busy, done, cell_data_rdy, cell_data_valid, cell_solved;
   logic       grid_solved, timeout_err;
   logic [3:0] cell_row, cell_col, cell_cmd, cell_data, pass;
   logic [6:0] solved_cnt;

   cell_sequencer #(.TIMEOUT(15), .MAX_PASS(9), .CMD_QUERY(4'h1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .cell_row(cell_row), .cell_col(cell_col), .cell_cmd(cell_cmd), .cell_data(cell_data),
      .cell_data_rdy(cell_data_rdy), .cell_data_valid(cell_data_valid), .cell_solved(cell_solved),
      .solved_cnt(solved_cnt), .pass(pass), .grid_solved(grid_solved), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct { logic [3:0] row, col, data; } strobe_t;
   typedef struct { logic [6:0] sc; logic [3:0] ps; logic grid, terr; int lat; } done_t;

   strobe_t exp_s[$];
   done_t   exp_d[$];
   int checks = 0, errors = 0;
   int cyc = 0, rise_cyc = 0, done_cnt = 0;
   logic busy_prev = 1'b0;

   // Responder configuration
   logic       resp_en = 1'b0, resp_solved = 1'b0, glitch = 1'b0, force_v = 1'b0, pending = 1'b0;
   logic [3:0] hang_row = 4'hF, hang_col = 4'hF;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic fail(input string name, input int act, input int req);
      checks++;
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
   endtask

   task automatic push_cells(input int passes, input int ncells);
      strobe_t s;
      for (int p = 0; p < passes; p++)
         for (int k = 0; k < ncells; k++) begin
            s.row  = 4'(k / 9);
            s.col  = 4'(k % 9);
            s.data = 4'(p);
            exp_s.push_back(s);
         end
   endtask

   task automatic push_done(input int sc, input int ps, input logic grid, input logic terr,
                            input int lat);
      done_t d;
      d.sc = 7'(sc); d.ps = 4'(ps); d.grid = grid; d.terr = terr; d.lat = lat;
      exp_d.push_back(d);
   endtask

   // Cell model: answers one cycle after the strobe (valid visible during WAIT).
   initial begin
      cell_data_valid = 1'b0;
      cell_solved     = 1'b0;
      forever begin
         @(negedge clk);
         cell_data_valid = 1'b0;
         cell_solved     = 1'b0;
         if (!rst_n) begin
            pending = 1'b0;
         end else begin
            if (pending) begin
               cell_data_valid = 1'b1;
               cell_solved     = resp_solved;
               pending         = 1'b0;
            end
            if (cell_data_rdy && resp_en) begin
               if (glitch) begin
                  cell_data_valid = 1'b1;
                  cell_solved     = 1'b1;
               end
               if (!(cell_row == hang_row && cell_col == hang_col)) pending = 1'b1;
            end
            if (force_v) begin
               cell_data_valid = 1'b1;
               cell_solved     = 1'b1;
            end
         end
      end
   end

   // Monitor
   always @(negedge clk) begin
      strobe_t s;
      done_t   d;
      cyc++;
      if (rst_n) begin
         if (busy && !busy_prev) rise_cyc = cyc;
         if (cell_data_rdy) begin
            if (exp_s.size() == 0) fail("strobe_unexpected", int'(cell_row) * 16 + int'(cell_col), -1);
            else begin
               s = exp_s.pop_front();
               chk("strobe_row", cell_row, s.row);
               chk("strobe_col", cell_col, s.col);
               chk("strobe_data", cell_data, s.data);
               chk("strobe_cmd", cell_cmd, 4'h1);
            end
         end else begin
            chk("idle_cmd", cell_cmd, 4'h0);
            chk("idle_data", cell_data, 4'h0);
         end
         if (done) begin
            done_cnt++;
            if (exp_d.size() == 0) fail("done_unexpected", cyc, -1);
            else begin
               d = exp_d.pop_front();
               chk("done_solved_cnt", solved_cnt, d.sc);
               chk("done_pass", pass, d.ps);
               chk("done_grid", grid_solved, d.grid);
               chk("done_timeout_err", timeout_err, d.terr);
               chk("done_busy", busy, 1'b1);
               chk("done_latency", cyc - rise_cyc, d.lat);
            end
         end
      end
      busy_prev = busy;
   end

   task automatic run(input int budget, input bit extra_starts);
      int d0;
      d0 = done_cnt;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int i = 0; i < budget && done_cnt == d0; i++) begin
         @(negedge clk);
         start = extra_starts && (i == 5 || i == 50 || i == 120 || i == 200);
      end
      start = 1'b0;
      if (done_cnt == d0) fail("done_wait_expired", budget, 0);
      repeat (6) @(negedge clk);
      chk("strobe_queue_drained", exp_s.size(), 0);
      chk("done_queue_drained", exp_d.size(), 0);
      chk("idle_after_run", busy, 1'b0);
      exp_s.delete();
      exp_d.delete();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_rdy"}, cell_data_rdy, 1'b0);
      chk({tag, "_cmd"}, cell_cmd, 4'h0);
      chk({tag, "_data"}, cell_data, 4'h0);
      chk({tag, "_row"}, cell_row, 4'h0);
      chk({tag, "_col"}, cell_col, 4'h0);
      chk({tag, "_solved_cnt"}, solved_cnt, 7'h0);
      chk({tag, "_pass"}, pass, 4'h0);
      chk({tag, "_grid"}, grid_solved, 1'b0);
      chk({tag, "_terr"}, timeout_err, 1'b0);
   endtask

   initial begin
      bit found;
      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      // One pass, every cell solved
      resp_en = 1'b1; resp_solved = 1'b1;
      push_cells(1, 81);
      push_done(81, 0, 1'b1, 1'b0, 244);
      run(400, 1'b0);

      // IDLE: valid pulses must not move anything
      force_v = 1'b1;
      repeat (5) @(negedge clk);
      force_v = 1'b0;
      @(negedge clk);
      chk("idle_valid_busy", busy, 1'b0);
      chk("idle_valid_row", cell_row, 4'h8);
      chk("idle_valid_solved_hold", solved_cnt, 7'd81);
      chk("idle_valid_grid_hold", grid_solved, 1'b1);

      // Never solved: all nine passes
      resp_solved = 1'b0;
      push_cells(9, 81);
      push_done(0, 8, 1'b0, 1'b0, 2196);
      run(2500, 1'b0);

      // start while busy is ignored
      resp_solved = 1'b1;
      push_cells(1, 81);
      push_done(81, 0, 1'b1, 1'b0, 244);
      run(400, 1'b1);

      // Reset at cell (3,2)
      push_cells(1, 30);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         found = cell_data_rdy && cell_row == 4'd3 && cell_col == 4'd2;
      end
      if (!found) fail("reach_cell_3_2", 0, 1);
      #1 rst_n = 1'b0;
      #1 chk_all_zero("midrun_reset");
      chk("midrun_strobes_seen", exp_s.size(), 0);
      exp_s.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      push_cells(1, 81);
      push_done(81, 0, 1'b1, 1'b0, 244);
      run(400, 1'b0);

      // valid during ISSUE (claiming solved) must be ignored
      glitch = 1'b1; resp_solved = 1'b0;
      push_cells(9, 81);
      push_done(0, 8, 1'b0, 1'b0, 2196);
      run(2500, 1'b0);
      glitch = 1'b0;

`ifdef CELL_SEQUENCER_TIMEOUT_EN
      // Cell (4,7) silent: 15-cycle WAIT each pass, other cells solved
      resp_solved = 1'b1; hang_row = 4'd4; hang_col = 4'd7;
      push_cells(9, 81);
      push_done(80, 8, 1'b0, 1'b1, 2322);
      run(2700, 1'b0);
      hang_row = 4'hF; hang_col = 4'hF;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
